// File: rtl/riscv_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_pipe
// Brief    : STAGES-deep MEM pipeline between EX and WB. A load waits in the
//            last slot until its dmem data has returned. Any pending exception
//            flushes every slot. The optional counters are enabled with
//            RISCV_MEM_PIPE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_pipe #(
    parameter int              XLEN    = 32,
    parameter int              ILEN    = 32,
    parameter int              EXC_W   = 16,
    parameter int              STAGES  = 2,
    parameter logic [XLEN-1:0] PC_INIT = 'h200
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    output logic             stall_o,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [ILEN-1:0]  instr_i,
    input  logic             bubble_i,
    input  logic             retired_i,
    input  logic             dbg_i,
    input  logic             is_load_i,
    input  logic [XLEN-1:0]  r_i,
    input  logic [XLEN-1:0]  memadr_i,
    input  logic [EXC_W-1:0] exc_dn_i,
    input  logic [EXC_W-1:0] exc_up_i,
    output logic [EXC_W-1:0] exc_up_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [ILEN-1:0]  instr_o,
    output logic             bubble_o,
    output logic             retired_o,
    output logic             dbg_o,
    output logic [XLEN-1:0]  r_o,
    output logic [XLEN-1:0]  memadr_o,
    output logic [EXC_W-1:0] exc_dn_o,
    input  logic             dmem_ack_i,
    input  logic [XLEN-1:0]  dmem_q_i,
    output logic             spurious_ack_o,
    output logic [31:0]      perf_wait_cnt_o,
    output logic [31:0]      perf_stall_cnt_o
);
    localparam int c_LAST  = STAGES - 1;
    localparam int c_IDX_W = 3;

    logic [XLEN-1:0]    r_pc_q     [STAGES];
    logic [XLEN-1:0]    w_pc_d     [STAGES];
    logic [ILEN-1:0]    r_instr_q  [STAGES];
    logic [ILEN-1:0]    w_instr_d  [STAGES];
    logic [XLEN-1:0]    r_r_q      [STAGES];
    logic [XLEN-1:0]    w_r_d      [STAGES];
    logic [XLEN-1:0]    w_r_upd    [STAGES];
    logic [XLEN-1:0]    r_memadr_q [STAGES];
    logic [XLEN-1:0]    w_memadr_d [STAGES];
    logic [EXC_W-1:0]   r_exc_q    [STAGES];
    logic [EXC_W-1:0]   w_exc_d    [STAGES];
    logic [STAGES-1:0]  r_bub_q, w_bub_d;
    logic [STAGES-1:0]  r_ret_q, w_ret_d;
    logic [STAGES-1:0]  r_dbg_q, w_dbg_d;
    logic [STAGES-1:0]  r_ld_q,  w_ld_d;
    logic [STAGES-1:0]  r_got_q, w_got_d, w_got_upd;
    logic               r_spur_q, w_spur_d;

    logic               w_tgt_vld;
    logic [c_IDX_W-1:0] w_tgt;
    logic               w_cap;
    logic               w_wait;
    logic               w_stall;
    logic               w_flush;
    logic [EXC_W-1:0]   w_exc_up;

    // Later (older) slots overwrite earlier hits, so the oldest pending load wins.
    always_comb begin
        w_tgt_vld = 1'b0;
        w_tgt     = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (!r_bub_q[k] && r_ld_q[k] && !r_got_q[k]) begin
                w_tgt_vld = 1'b1;
                w_tgt     = c_IDX_W'(k);
            end
        end
    end

    assign w_cap = dmem_ack_i & w_tgt_vld;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_r_upd[k]   = r_r_q[k];
            w_got_upd[k] = r_got_q[k];
            if (w_cap && (w_tgt == c_IDX_W'(k))) begin
                w_r_upd[k]   = dmem_q_i;
                w_got_upd[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_exc_up = exc_up_i;
        for (int k = 0; k < STAGES; k++) begin
            w_exc_up = w_exc_up | r_exc_q[k];
        end
    end

    assign w_wait   = ~r_bub_q[c_LAST] & r_ld_q[c_LAST] & ~r_got_q[c_LAST] & ~dmem_ack_i;
    assign w_stall  = stall_i | w_wait;
    assign w_flush  = |w_exc_up;
    assign w_spur_d = r_spur_q | (dmem_ack_i & ~w_tgt_vld);

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_pc_d[k]     = r_pc_q[k];
            w_instr_d[k]  = r_instr_q[k];
            w_memadr_d[k] = r_memadr_q[k];
            w_exc_d[k]    = r_exc_q[k];
            w_bub_d[k]    = r_bub_q[k];
            w_ret_d[k]    = r_ret_q[k];
            w_dbg_d[k]    = r_dbg_q[k];
            w_ld_d[k]     = r_ld_q[k];
            w_r_d[k]      = w_r_upd[k];
            w_got_d[k]    = w_got_upd[k];
        end
        if (w_flush) begin
            // A flush drops any load return seen in the same cycle.
            for (int k = 0; k < STAGES; k++) begin
                w_bub_d[k] = 1'b1;
                w_ret_d[k] = 1'b0;
                w_exc_d[k] = '0;
                w_got_d[k] = 1'b0;
                w_r_d[k]   = r_r_q[k];
            end
        end else if (!w_stall) begin
            w_pc_d[0]     = pc_i;
            w_instr_d[0]  = instr_i;
            w_memadr_d[0] = memadr_i;
            w_exc_d[0]    = exc_dn_i;
            w_bub_d[0]    = bubble_i;
            w_ret_d[0]    = retired_i;
            w_dbg_d[0]    = dbg_i;
            w_ld_d[0]     = is_load_i;
            w_r_d[0]      = r_i;
            w_got_d[0]    = 1'b0;
            for (int k = 1; k < STAGES; k++) begin
                w_pc_d[k]     = r_pc_q[k-1];
                w_instr_d[k]  = r_instr_q[k-1];
                w_memadr_d[k] = r_memadr_q[k-1];
                w_exc_d[k]    = r_exc_q[k-1];
                w_bub_d[k]    = r_bub_q[k-1];
                w_ret_d[k]    = r_ret_q[k-1];
                w_dbg_d[k]    = r_dbg_q[k-1];
                w_ld_d[k]     = r_ld_q[k-1];
                w_r_d[k]      = w_r_upd[k-1];
                w_got_d[k]    = w_got_upd[k-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                r_pc_q[k]     <= PC_INIT;
                r_instr_q[k]  <= '0;
                r_r_q[k]      <= '0;
                r_memadr_q[k] <= '0;
                r_exc_q[k]    <= '0;
            end
            r_bub_q  <= '1;
            r_ret_q  <= '0;
            r_dbg_q  <= '0;
            r_ld_q   <= '0;
            r_got_q  <= '0;
            r_spur_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                r_pc_q[k]     <= w_pc_d[k];
                r_instr_q[k]  <= w_instr_d[k];
                r_r_q[k]      <= w_r_d[k];
                r_memadr_q[k] <= w_memadr_d[k];
                r_exc_q[k]    <= w_exc_d[k];
            end
            r_bub_q  <= w_bub_d;
            r_ret_q  <= w_ret_d;
            r_dbg_q  <= w_dbg_d;
            r_ld_q   <= w_ld_d;
            r_got_q  <= w_got_d;
            r_spur_q <= w_spur_d;
        end
    end

    assign stall_o        = w_stall;
    assign exc_up_o       = w_exc_up;
    assign pc_o           = r_pc_q[c_LAST];
    assign instr_o        = r_instr_q[c_LAST];
    assign bubble_o       = r_bub_q[c_LAST];
    assign retired_o      = r_ret_q[c_LAST];
    assign dbg_o          = r_dbg_q[c_LAST];
    assign r_o            = w_r_upd[c_LAST];
    assign memadr_o       = r_memadr_q[c_LAST];
    assign exc_dn_o       = r_exc_q[c_LAST];
    assign spurious_ack_o = r_spur_q;

`ifdef RISCV_MEM_PIPE_PERF_EN
    logic [31:0] r_wait_cnt_q, w_wait_cnt_d;
    logic [31:0] r_stall_cnt_q, w_stall_cnt_d;

    always_comb begin
        w_wait_cnt_d  = r_wait_cnt_q;
        w_stall_cnt_d = r_stall_cnt_q;
        if (w_wait && (r_wait_cnt_q != '1)) begin
            w_wait_cnt_d = r_wait_cnt_q + 32'd1;
        end
        if (w_stall && (r_stall_cnt_q != '1)) begin
            w_stall_cnt_d = r_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wait_cnt_q  <= '0;
            r_stall_cnt_q <= '0;
        end else begin
            r_wait_cnt_q  <= w_wait_cnt_d;
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign perf_wait_cnt_o  = r_wait_cnt_q;
    assign perf_stall_cnt_o = r_stall_cnt_q;
`else
    assign perf_wait_cnt_o  = 32'd0;
    assign perf_stall_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mem_pipe
// Brief    : Self-checking bench for riscv_mem_pipe: directed scenarios plus
//            random traffic compared against a slot-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_pipe;
    localparam int          XLEN    = 32;
    localparam int          ILEN    = 32;
    localparam int          EXC_W   = 16;
    localparam int          STAGES  = 2;
    localparam logic [31:0] PC_INIT = 32'h200;

    logic             clk = 1'b0;
    logic             rst_i, stall_i, stall_o;
    logic [XLEN-1:0]  pc_i, r_i, memadr_i, pc_o, r_o, memadr_o, dmem_q_i;
    logic [ILEN-1:0]  instr_i, instr_o;
    logic             bubble_i, retired_i, dbg_i, is_load_i;
    logic             bubble_o, retired_o, dbg_o, dmem_ack_i, spurious_ack_o;
    logic [EXC_W-1:0] exc_dn_i, exc_up_i, exc_up_o, exc_dn_o;
    logic [31:0]      perf_wait_cnt_o, perf_stall_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    riscv_mem_pipe #(
        .XLEN(XLEN), .ILEN(ILEN), .EXC_W(EXC_W), .STAGES(STAGES), .PC_INIT(PC_INIT)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .stall_o(stall_o),
        .pc_i(pc_i), .instr_i(instr_i), .bubble_i(bubble_i), .retired_i(retired_i),
        .dbg_i(dbg_i), .is_load_i(is_load_i), .r_i(r_i), .memadr_i(memadr_i),
        .exc_dn_i(exc_dn_i), .exc_up_i(exc_up_i), .exc_up_o(exc_up_o),
        .pc_o(pc_o), .instr_o(instr_o), .bubble_o(bubble_o), .retired_o(retired_o),
        .dbg_o(dbg_o), .r_o(r_o), .memadr_o(memadr_o), .exc_dn_o(exc_dn_o),
        .dmem_ack_i(dmem_ack_i), .dmem_q_i(dmem_q_i), .spurious_ack_o(spurious_ack_o),
        .perf_wait_cnt_o(perf_wait_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
    );

    // Reference model: list of in-flight instructions, index STAGES-1 is oldest.
    typedef struct {
        logic [31:0] pc, instr, r, adr;
        logic [15:0] exc;
        logic        bub, ret, dbg, ld, got;
    } slot_t;

    slot_t       m [STAGES];
    logic        m_spur;
    logic [31:0] m_wcnt, m_scnt;

    function automatic int m_oldest_load();
        for (int k = STAGES - 1; k >= 0; k--)
            if (!m[k].bub && m[k].ld && !m[k].got) return k;
        return -1;
    endfunction

    function automatic logic m_wait();
        return !m[STAGES-1].bub && m[STAGES-1].ld && !m[STAGES-1].got && !dmem_ack_i;
    endfunction

    function automatic logic [15:0] m_exc_up();
        logic [15:0] v;
        v = exc_up_i;
        for (int k = 0; k < STAGES; k++) v = v | m[k].exc;
        return v;
    endfunction

    function automatic logic [31:0] m_r_out();
        if (dmem_ack_i && m_oldest_load() == STAGES - 1) return dmem_q_i;
        return m[STAGES-1].r;
    endfunction

    task automatic model_edge();
        int   t;
        logic w, s, fl;
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                m[k].pc = PC_INIT; m[k].instr = 0; m[k].r = 0; m[k].adr = 0; m[k].exc = 0;
                m[k].bub = 1; m[k].ret = 0; m[k].dbg = 0; m[k].ld = 0; m[k].got = 0;
            end
            m_spur = 0; m_wcnt = 0; m_scnt = 0;
            return;
        end
        t  = m_oldest_load();
        w  = m_wait();
        s  = stall_i | w;
        fl = (m_exc_up() != 0);
        if (w && m_wcnt != 32'hFFFF_FFFF) m_wcnt = m_wcnt + 1;
        if (s && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
        if (dmem_ack_i && t < 0) m_spur = 1;
        if (fl) begin
            for (int k = 0; k < STAGES; k++) begin
                m[k].bub = 1; m[k].ret = 0; m[k].exc = 0; m[k].got = 0;
            end
        end else begin
            if (dmem_ack_i && t >= 0) begin
                m[t].r = dmem_q_i; m[t].got = 1;
            end
            if (!s) begin
                for (int k = STAGES - 1; k > 0; k--) m[k] = m[k-1];
                m[0].pc = pc_i; m[0].instr = instr_i; m[0].r = r_i; m[0].adr = memadr_i;
                m[0].exc = exc_dn_i; m[0].bub = bubble_i; m[0].ret = retired_i;
                m[0].dbg = dbg_i; m[0].ld = is_load_i; m[0].got = 0;
            end
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall_i = 0; pc_i = 0; instr_i = 0; bubble_i = 1; retired_i = 0; dbg_i = 0;
        is_load_i = 0; r_i = 0; memadr_i = 0; exc_dn_i = 0; exc_up_i = 0;
        dmem_ack_i = 0; dmem_q_i = 0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic ld, input logic [15:0] exc);
        idle_inputs();
        pc_i = pc; instr_i = pc ^ 32'h13; bubble_i = 0; retired_i = 1; is_load_i = ld;
        r_i = pc + 32'h1000; memadr_i = pc + 32'h8000; exc_dn_i = exc;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1;
        clk_step();
        rst_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks += 6;
        if (bubble_o !== 1'b1) begin n_fail++; $display("FAIL reset_bubble got=%0h exp=1", bubble_o); end
        if (pc_o !== PC_INIT) begin n_fail++; $display("FAIL reset_pc got=%0h exp=%0h", pc_o, PC_INIT); end
        if (retired_o !== 1'b0 || dbg_o !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%0h%0h exp=00", retired_o, dbg_o); end
        if (exc_dn_o !== 0 || exc_up_o !== 0) begin n_fail++; $display("FAIL reset_exc got=%0h/%0h exp=0", exc_dn_o, exc_up_o); end
        if (r_o !== 0 || instr_o !== 0 || memadr_o !== 0) begin n_fail++; $display("FAIL reset_data got=%0h/%0h/%0h exp=0", r_o, instr_o, memadr_o); end
        if (spurious_ack_o !== 0 || stall_o !== 0) begin n_fail++; $display("FAIL reset_spur_stall got=%0h/%0h exp=0", spurious_ack_o, stall_o); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 4) issue(32'h100 + 32'(4 * i), 0, 0); else idle_inputs();
            #1;
            n_checks++;
            if (stall_o !== 1'b0) begin n_fail++; $display("FAIL stream_stall cyc=%0d got=%0h exp=0", i, stall_o); end
            if (i >= 2 && i < 6) begin
                exp_pc = 32'h100 + 32'(4 * (i - 2));
                n_checks++;
                if (pc_o !== exp_pc || bubble_o !== 1'b0) begin
                    n_fail++; $display("FAIL stream_pc cyc=%0d got=%0h/%0h exp=%0h/0", i, pc_o, bubble_o, exp_pc);
                end
            end
            clk_step();
        end
    endtask

    task automatic test_load_wait();
        do_reset();
        issue(32'h200, 1, 0);
        clk_step();
        idle_inputs();
        clk_step();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (stall_o !== 1'b1 || bubble_o !== 1'b0) begin n_fail++; $display("FAIL load_wait_stall cyc=%0d got=%0h exp=1", i, stall_o); end
            clk_step();
        end
        dmem_ack_i = 1; dmem_q_i = 32'hDEADBEEF;
        #1;
        n_checks += 2;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL load_ack_stall got=%0h exp=0", stall_o); end
        if (r_o !== 32'hDEADBEEF || pc_o !== 32'h200) begin n_fail++; $display("FAIL load_ack_data got=%0h@%0h exp=deadbeef@200", r_o, pc_o); end
        clk_step();
        idle_inputs();
        #1;
        n_checks++;
        if (bubble_o !== 1'b1 || spurious_ack_o !== 1'b0) begin n_fail++; $display("FAIL load_after got=%0h/%0h exp=1/0", bubble_o, spurious_ack_o); end
    endtask

    task automatic test_early_ack();
        do_reset();
        issue(32'h300, 1, 0);
        clk_step();
        idle_inputs();
        dmem_ack_i = 1; dmem_q_i = 32'h1234;
        clk_step();
        idle_inputs();
        #1;
        n_checks += 2;
        if (stall_o !== 1'b0 || bubble_o !== 1'b0) begin n_fail++; $display("FAIL early_ack_stall got=%0h/%0h exp=0/0", stall_o, bubble_o); end
        if (r_o !== 32'h1234 || pc_o !== 32'h300 || spurious_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL early_ack_data got=%0h@%0h spur=%0h exp=1234@300", r_o, pc_o, spurious_ack_o);
        end
    endtask

    task automatic test_exc_flush();
        do_reset();
        issue(32'h400, 0, 16'h0008);
        clk_step();
        issue(32'h404, 0, 0);
        #1;
        n_checks++;
        if (exc_up_o !== 16'h0008) begin n_fail++; $display("FAIL exc_up got=%0h exp=8", exc_up_o); end
        clk_step();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (bubble_o !== 1'b1 || retired_o !== 1'b0 || exc_dn_o !== 0 || exc_up_o !== 0) begin
                n_fail++; $display("FAIL exc_flush cyc=%0d got=%0h/%0h/%0h/%0h exp=1/0/0/0", i, bubble_o, retired_o, exc_dn_o, exc_up_o);
            end
            clk_step();
        end
    endtask

    task automatic test_spurious();
        do_reset();
        dmem_ack_i = 1; dmem_q_i = 32'h55;
        #1;
        n_checks++;
        if (spurious_ack_o !== 1'b0) begin n_fail++; $display("FAIL spur_pre got=%0h exp=0", spurious_ack_o); end
        clk_step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (spurious_ack_o !== 1'b1) begin n_fail++; $display("FAIL spur_sticky cyc=%0d got=%0h exp=1", i, spurious_ack_o); end
            clk_step();
        end
        do_reset();
        #1;
        n_checks++;
        if (spurious_ack_o !== 1'b0) begin n_fail++; $display("FAIL spur_reset got=%0h exp=0", spurious_ack_o); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        issue(32'h500, 1, 0);
        clk_step();
        idle_inputs();
        clk_step();
        #1;
        n_checks++;
        if (stall_o !== 1'b1) begin n_fail++; $display("FAIL mid_stall_pre got=%0h exp=1", stall_o); end
        rst_i = 1; stall_i = 1;
        clk_step();
        rst_i = 0;
        #1;
        n_checks++;
        if (stall_o !== 1'b1 || bubble_o !== 1'b1 || pc_o !== PC_INIT) begin
            n_fail++; $display("FAIL mid_stall_rst got=%0h/%0h/%0h exp=1/1/200", stall_o, bubble_o, pc_o);
        end
        stall_i = 0;
        #1;
        n_checks++;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL mid_stall_rel got=%0h exp=0", stall_o); end
        clk_step();
    endtask

    task automatic test_random();
        logic [31:0] ew, es;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bubble_i   = ($urandom_range(0, 3) == 0);
            is_load_i  = ($urandom_range(0, 2) == 0);
            pc_i       = $urandom; instr_i = $urandom; r_i = $urandom; memadr_i = $urandom;
            retired_i  = $urandom_range(0, 1); dbg_i = $urandom_range(0, 1);
            exc_dn_i   = ($urandom_range(0, 24) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
            exc_up_i   = ($urandom_range(0, 49) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
            stall_i    = ($urandom_range(0, 4) == 0);
            dmem_ack_i = ($urandom_range(0, 2) == 0);
            dmem_q_i   = $urandom;
            #1;
            n_checks += 8;
            if (stall_o !== (stall_i | m_wait())) begin n_fail++; $display("FAIL rnd_stall cyc=%0d got=%0h exp=%0h", i, stall_o, stall_i | m_wait()); end
            if (exc_up_o !== m_exc_up()) begin n_fail++; $display("FAIL rnd_exc_up cyc=%0d got=%0h exp=%0h", i, exc_up_o, m_exc_up()); end
            if (pc_o !== m[STAGES-1].pc || instr_o !== m[STAGES-1].instr) begin
                n_fail++; $display("FAIL rnd_pc_instr cyc=%0d got=%0h/%0h exp=%0h/%0h", i, pc_o, instr_o, m[STAGES-1].pc, m[STAGES-1].instr);
            end
            if (bubble_o !== m[STAGES-1].bub || retired_o !== m[STAGES-1].ret || dbg_o !== m[STAGES-1].dbg) begin
                n_fail++; $display("FAIL rnd_flags cyc=%0d got=%0h%0h%0h exp=%0h%0h%0h", i, bubble_o, retired_o, dbg_o,
                                   m[STAGES-1].bub, m[STAGES-1].ret, m[STAGES-1].dbg);
            end
            if (r_o !== m_r_out()) begin n_fail++; $display("FAIL rnd_r cyc=%0d got=%0h exp=%0h", i, r_o, m_r_out()); end
            if (memadr_o !== m[STAGES-1].adr || exc_dn_o !== m[STAGES-1].exc) begin
                n_fail++; $display("FAIL rnd_adr_exc cyc=%0d got=%0h/%0h exp=%0h/%0h", i, memadr_o, exc_dn_o, m[STAGES-1].adr, m[STAGES-1].exc);
            end
            if (spurious_ack_o !== m_spur) begin n_fail++; $display("FAIL rnd_spur cyc=%0d got=%0h exp=%0h", i, spurious_ack_o, m_spur); end
`ifdef RISCV_MEM_PIPE_PERF_EN
            ew = m_wcnt; es = m_scnt;
`else
            ew = 0; es = 0;
`endif
            if (perf_wait_cnt_o !== ew || perf_stall_cnt_o !== es) begin
                n_fail++; $display("FAIL rnd_perf cyc=%0d got=%0h/%0h exp=%0h/%0h", i, perf_wait_cnt_o, perf_stall_cnt_o, ew, es);
            end
            clk_step();
        end
    endtask

    initial begin
        rst_i = 1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_stream();
        test_load_wait();
        test_early_ack();
        test_exc_flush();
        test_spurious();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
